combat_sched: RTL and testbench

COMBAT_SCHED -- requirements
Module: combat_sched

---
 rtl/combat_sched.sv | 203 ++++++++++++++++++++
 tb/tb_combat_sched.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/combat_sched.sv
// combat_sched: two-fighter combat round scheduler (player P1 vs CPU).
//
// A round runs in FIGHT. Each fighter may attack when its cooldown
// counter is zero. P1 attacks on the rising edge of keyboard_input[0];
// the CPU attacks whenever cpu_attack_req is high. Simultaneous eligible
// requests are arbitrated round-robin using the last granted fighter.
// The round ends (OVER) as soon as a hit takes a fighter's health to 0.
//
// Optional build macro:
//   COMBAT_BLOCK_EN - when defined, a fighter that is blocking in the
//                     grant cycle (P1: keyboard_input[1], CPU: cpu_block)
//                     takes no damage from the granted attack.
//                     When undefined, both block inputs are ignored.
//
// Ports:
//   clk             in   system clock, rising edge
//   reset           in   synchronous active-high reset
//   start           in   begin a round (sampled in IDLE/OVER)
//   keyboard_input  in   [0] P1 attack, [1] P1 block, [3:2] unused
//   cpu_attack_req  in   CPU attack request (level)
//   cpu_block       in   CPU block (level)
//   p1_health_out   out  P1 health (registered)
//   cpu_health_out  out  CPU health (registered)
//   cpu_isAttacking out  one-cycle pulse on CPU grant
//   p1_isAttacking  out  one-cycle pulse on P1 grant
//   round_active    out  high while in FIGHT
//   winner          out  00 none, 01 P1, 10 CPU

module combat_sched #(
    parameter int unsigned MAX_HEALTH = 100,
    parameter int unsigned DAMAGE     = 30,
    parameter int unsigned COOLDOWN   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] keyboard_input,
    input  logic       cpu_attack_req,
    input  logic       cpu_block,
    output logic [7:0] p1_health_out,
    output logic [7:0] cpu_health_out,
    output logic       cpu_isAttacking,
    output logic       p1_isAttacking,
    output logic       round_active,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIGHT = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_P1  = 1'b0,
        GRANT_CPU = 1'b1
    } grant_t;

    localparam logic [7:0] MAX_HP  = 8'(MAX_HEALTH);
    localparam logic [7:0] DMG     = 8'(DAMAGE);
    localparam logic [3:0] CD_LOAD = 4'(COOLDOWN);

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_CPU  = 2'b10;

    state_t     state_q, state_d;
    logic [7:0] p1_hp_q, p1_hp_d;
    logic [7:0] cpu_hp_q, cpu_hp_d;
    logic [3:0] p1_cd_q, p1_cd_d;
    logic [3:0] cpu_cd_q, cpu_cd_d;
    logic       key_prev_q, key_prev_d;
    grant_t     last_grant_q, last_grant_d;
    logic [1:0] winner_q, winner_d;
    logic       p1_pulse_q, p1_pulse_d;
    logic       cpu_pulse_q, cpu_pulse_d;

    logic       p1_blocking;
    logic       cpu_blocking;
    logic       unused_inputs;

`ifdef COMBAT_BLOCK_EN
    assign p1_blocking   = keyboard_input[1];
    assign cpu_blocking  = cpu_block;
    assign unused_inputs = ^keyboard_input[3:2];
`else
    assign p1_blocking   = 1'b0;
    assign cpu_blocking  = 1'b0;
    assign unused_inputs = ^{keyboard_input[3:1], cpu_block};
`endif

    // Saturating damage; a blocked hit leaves health untouched.
    function automatic logic [7:0] apply_hit(input logic [7:0] hp, input logic blocked);
        if (blocked) begin
            return hp;
        end else if (hp <= DMG) begin
            return '0;
        end else begin
            return hp - DMG;
        end
    endfunction

    logic       fighting;
    logic       p1_edge;
    logic       p1_elig;
    logic       cpu_elig;
    logic       grant_p1;
    logic       grant_cpu;
    logic [7:0] p1_hit_hp;
    logic [7:0] cpu_hit_hp;

    assign fighting   = (state_q == ST_FIGHT);
    assign p1_edge    = keyboard_input[0] & ~key_prev_q;
    assign p1_elig    = fighting && p1_edge && (p1_cd_q == '0);
    assign cpu_elig   = fighting && cpu_attack_req && (cpu_cd_q == '0);
    // On a tie the fighter not granted last wins; the loser simply is not granted.
    assign grant_p1   = p1_elig && (!cpu_elig || (last_grant_q == GRANT_CPU));
    assign grant_cpu  = cpu_elig && !grant_p1;
    assign p1_hit_hp  = apply_hit(p1_hp_q, p1_blocking);
    assign cpu_hit_hp = apply_hit(cpu_hp_q, cpu_blocking);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            p1_hp_q      <= MAX_HP;
            cpu_hp_q     <= MAX_HP;
            p1_cd_q      <= '0;
            cpu_cd_q     <= '0;
            key_prev_q   <= 1'b0;
            last_grant_q <= GRANT_CPU;
            winner_q     <= WIN_NONE;
            p1_pulse_q   <= 1'b0;
            cpu_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            p1_hp_q      <= p1_hp_d;
            cpu_hp_q     <= cpu_hp_d;
            p1_cd_q      <= p1_cd_d;
            cpu_cd_q     <= cpu_cd_d;
            key_prev_q   <= key_prev_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            p1_pulse_q   <= p1_pulse_d;
            cpu_pulse_q  <= cpu_pulse_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        p1_hp_d      = p1_hp_q;
        cpu_hp_d     = cpu_hp_q;
        p1_cd_d      = (p1_cd_q == '0) ? '0 : p1_cd_q - 4'd1;
        cpu_cd_d     = (cpu_cd_q == '0) ? '0 : cpu_cd_q - 4'd1;
        key_prev_d   = keyboard_input[0];
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        p1_pulse_d   = 1'b0;
        cpu_pulse_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d  = ST_FIGHT;
                    p1_hp_d  = MAX_HP;
                    cpu_hp_d = MAX_HP;
                    p1_cd_d  = '0;
                    cpu_cd_d = '0;
                    winner_d = WIN_NONE;
                end
            end
            ST_FIGHT: begin
                if (grant_p1) begin
                    p1_pulse_d   = 1'b1;
                    p1_cd_d      = CD_LOAD;
                    last_grant_d = GRANT_P1;
                    cpu_hp_d     = cpu_hit_hp;
                    if (cpu_hit_hp == '0) begin
                        state_d  = ST_OVER;
                        winner_d = WIN_P1;
                    end
                end else if (grant_cpu) begin
                    cpu_pulse_d  = 1'b1;
                    cpu_cd_d     = CD_LOAD;
                    last_grant_d = GRANT_CPU;
                    p1_hp_d      = p1_hit_hp;
                    if (p1_hit_hp == '0) begin
                        state_d  = ST_OVER;
                        winner_d = WIN_CPU;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign p1_health_out   = p1_hp_q;
    assign cpu_health_out  = cpu_hp_q;
    assign p1_isAttacking  = p1_pulse_q;
    assign cpu_isAttacking = cpu_pulse_q;
    assign round_active    = (state_q == ST_FIGHT);
    assign winner          = winner_q;

endmodule

// File: tb/tb_combat_sched.sv
// Testbench for combat_sched. Expected grants (who, resulting healths) are
// queued before the stimulus that should cause them; a monitor pops one
// entry per observed attack pulse and compares.

module tb_combat_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] keyboard_input;
    logic       cpu_attack_req;
    logic       cpu_block;
    logic [7:0] p1_health_out;
    logic [7:0] cpu_health_out;
    logic       cpu_isAttacking;
    logic       p1_isAttacking;
    logic       round_active;
    logic [1:0] winner;

    always #5 clk = ~clk;

    combat_sched #(
        .MAX_HEALTH(100),
        .DAMAGE    (30),
        .COOLDOWN  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .keyboard_input (keyboard_input),
        .cpu_attack_req (cpu_attack_req),
        .cpu_block      (cpu_block),
        .p1_health_out  (p1_health_out),
        .cpu_health_out (cpu_health_out),
        .cpu_isAttacking(cpu_isAttacking),
        .p1_isAttacking (p1_isAttacking),
        .round_active   (round_active),
        .winner         (winner)
    );

`ifdef COMBAT_BLOCK_EN
    localparam logic [7:0] BLOCKED_P1_HP = 8'd100;
`else
    localparam logic [7:0] BLOCKED_P1_HP = 8'd70;
`endif

    typedef struct {
        logic       who;   // 0 = P1, 1 = CPU
        logic [7:0] p1;
        logic [7:0] cpu;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Scoreboard monitor: every attack pulse must match the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (p1_isAttacking || cpu_isAttacking) begin
            checks++;
            if (p1_isAttacking && cpu_isAttacking) begin
                errors++;
                $display("FAIL dual_pulse p1=%0b cpu=%0b required only one", p1_isAttacking, cpu_isAttacking);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant p1_pulse=%0b cpu_pulse=%0b p1=%0d cpu=%0d required no grant",
                         p1_isAttacking, cpu_isAttacking, p1_health_out, cpu_health_out);
            end else begin
                mon_e = sb.pop_front();
                if (cpu_isAttacking !== mon_e.who || p1_health_out !== mon_e.p1 ||
                    cpu_health_out !== mon_e.cpu) begin
                    errors++;
                    $display("FAIL grant got who=%0d p1=%0d cpu=%0d required who=%0d p1=%0d cpu=%0d",
                             cpu_isAttacking, p1_health_out, cpu_health_out,
                             mon_e.who, mon_e.p1, mon_e.cpu);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input logic who, input logic [7:0] p1, input logic [7:0] cpu);
        exp_t e;
        e.who = who;
        e.p1  = p1;
        e.cpu = cpu;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        start          = 1'b0;
        keyboard_input = 4'b0000;
        cpu_attack_req = 1'b0;
        cpu_block      = 1'b0;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic begin_round();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (round_active !== 1'b0 || winner !== 2'b00 || p1_isAttacking !== 1'b0 || cpu_isAttacking !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl active=%0b winner=%0b pulses=%0b%0b required 0 00 00",
                     round_active, winner, p1_isAttacking, cpu_isAttacking);
        end
        checks++;
        if (p1_health_out !== 8'd100 || cpu_health_out !== 8'd100) begin
            errors++;
            $display("FAIL reset_health p1=%0d cpu=%0d required 100 100", p1_health_out, cpu_health_out);
        end
        begin_round();
        checks++;
        if (round_active !== 1'b1 || winner !== 2'b00 || p1_health_out !== 8'd100 || cpu_health_out !== 8'd100) begin
            errors++;
            $display("FAIL start_round active=%0b winner=%0b p1=%0d cpu=%0d required 1 00 100 100",
                     round_active, winner, p1_health_out, cpu_health_out);
        end
    endtask

    task automatic test_p1_attack();
        do_reset();
        begin_round();
        push_exp(1'b0, 8'd100, 8'd70);
        keyboard_input = 4'b0001;
        tick(1);
        checks++;
        if (cpu_health_out !== 8'd70) begin
            errors++;
            $display("FAIL p1_hit cpu=%0d required 70", cpu_health_out);
        end
        tick(2);
        keyboard_input = 4'b0000;
        tick(1);
        keyboard_input = 4'b0001;   // new edge while still cooling down
        tick(1);
        checks++;
        if (p1_isAttacking !== 1'b0 || cpu_health_out !== 8'd70) begin
            errors++;
            $display("FAIL p1_cooldown pulse=%0b cpu=%0d required 0 70", p1_isAttacking, cpu_health_out);
        end
        tick(3);
        // start in FIGHT and upper key bits must have no effect
        keyboard_input = 4'b1101;
        start = 1'b1;
        tick(1);
        keyboard_input = 4'b0001;
        start = 1'b0;
        tick(1);
        keyboard_input = 4'b1101;
        tick(1);
        keyboard_input = 4'b0001;
        tick(2);
        checks++;
        if (round_active !== 1'b1 || p1_health_out !== 8'd100 || cpu_health_out !== 8'd70) begin
            errors++;
            $display("FAIL start_in_fight active=%0b p1=%0d cpu=%0d required 1 100 70",
                     round_active, p1_health_out, cpu_health_out);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL p1_pending got %0d required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_tie();
        do_reset();
        begin_round();
        // fresh round: P1 wins the tie, CPU follows once P1 is cooling down
        push_exp(1'b0, 8'd100, 8'd70);
        push_exp(1'b1, 8'd70, 8'd70);
        keyboard_input = 4'b0001;
        cpu_attack_req = 1'b1;
        tick(2);
        cpu_attack_req = 1'b0;
        keyboard_input = 4'b0000;
        tick(4);
        // last grant CPU: P1 wins again
        push_exp(1'b0, 8'd70, 8'd40);
        push_exp(1'b1, 8'd40, 8'd40);
        keyboard_input = 4'b0001;
        cpu_attack_req = 1'b1;
        tick(2);
        cpu_attack_req = 1'b0;
        keyboard_input = 4'b0000;
        tick(4);
        push_exp(1'b0, 8'd40, 8'd10);
        keyboard_input = 4'b0001;
        tick(1);
        keyboard_input = 4'b0000;
        tick(4);
        // last grant P1: CPU wins the tie and P1's edge is lost
        push_exp(1'b1, 8'd10, 8'd10);
        keyboard_input = 4'b0001;
        cpu_attack_req = 1'b1;
        tick(1);
        cpu_attack_req = 1'b0;
        tick(4);
        checks++;
        if (p1_health_out !== 8'd10 || cpu_health_out !== 8'd10 || round_active !== 1'b1) begin
            errors++;
            $display("FAIL tie_final p1=%0d cpu=%0d active=%0b required 10 10 1",
                     p1_health_out, cpu_health_out, round_active);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL tie_pending got %0d required 0", sb.size());
        end
        sb.delete();
        keyboard_input = 4'b0000;
    endtask

    task automatic test_knockout();
        logic [7:0] ko_exp [4];
        ko_exp[0] = 8'd70;
        ko_exp[1] = 8'd40;
        ko_exp[2] = 8'd10;
        ko_exp[3] = 8'd0;
        do_reset();
        begin_round();
        for (int i = 0; i < 4; i++) begin
            push_exp(1'b0, 8'd100, ko_exp[i]);
            keyboard_input = 4'b0001;
            tick(1);
            keyboard_input = 4'b0000;
            if (i == 3) begin
                checks++;
                if (round_active !== 1'b0 || winner !== 2'b01) begin
                    errors++;
                    $display("FAIL ko_state active=%0b winner=%0b required 0 01", round_active, winner);
                end
            end
            tick(5);
        end
        // OVER ignores all requests
        keyboard_input = 4'b0001;
        cpu_attack_req = 1'b1;
        tick(2);
        keyboard_input = 4'b0000;
        tick(1);
        keyboard_input = 4'b0001;
        tick(3);
        cpu_attack_req = 1'b0;
        keyboard_input = 4'b0000;
        checks++;
        if (p1_health_out !== 8'd100 || cpu_health_out !== 8'd0 || winner !== 2'b01 || round_active !== 1'b0) begin
            errors++;
            $display("FAIL over_hold p1=%0d cpu=%0d winner=%0b active=%0b required 100 0 01 0",
                     p1_health_out, cpu_health_out, winner, round_active);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL ko_pending got %0d required 0", sb.size());
        end
        sb.delete();
        begin_round();
        checks++;
        if (round_active !== 1'b1 || winner !== 2'b00 || p1_health_out !== 8'd100 || cpu_health_out !== 8'd100) begin
            errors++;
            $display("FAIL restart active=%0b winner=%0b p1=%0d cpu=%0d required 1 00 100 100",
                     round_active, winner, p1_health_out, cpu_health_out);
        end
    endtask

    task automatic test_block();
        do_reset();
        begin_round();
        push_exp(1'b1, BLOCKED_P1_HP, 8'd100);
        keyboard_input = 4'b0010;
        cpu_attack_req = 1'b1;
        tick(1);
        cpu_attack_req = 1'b0;
        tick(1);
        checks++;
        if (p1_health_out !== BLOCKED_P1_HP) begin
            errors++;
            $display("FAIL block p1=%0d required %0d", p1_health_out, BLOCKED_P1_HP);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL block_pending got %0d required 0", sb.size());
        end
        sb.delete();
        keyboard_input = 4'b0000;
    endtask

    task automatic test_reset_mid_round();
        do_reset();
        begin_round();
        push_exp(1'b1, 8'd70, 8'd100);
        push_exp(1'b1, 8'd40, 8'd100);
        cpu_attack_req = 1'b1;
        tick(6);
        cpu_attack_req = 1'b0;
        checks++;
        if (p1_health_out !== 8'd40) begin
            errors++;
            $display("FAIL mid_setup p1=%0d required 40", p1_health_out);
        end
        // reset alongside start and an eligible P1 edge: reset must win
        reset          = 1'b1;
        start          = 1'b1;
        keyboard_input = 4'b0001;
        tick(1);
        checks++;
        if (round_active !== 1'b0 || p1_health_out !== 8'd100 || cpu_health_out !== 8'd100 ||
            p1_isAttacking !== 1'b0 || cpu_isAttacking !== 1'b0 || winner !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset active=%0b p1=%0d cpu=%0d pulses=%0b%0b winner=%0b required 0 100 100 00 00",
                     round_active, p1_health_out, cpu_health_out, p1_isAttacking, cpu_isAttacking, winner);
        end
        reset          = 1'b0;
        start          = 1'b0;
        keyboard_input = 4'b0000;
        tick(2);
        checks++;
        if (round_active !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset active=%0b required 0", round_active);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL mid_pending got %0d required 0", sb.size());
        end
        sb.delete();
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        keyboard_input = 4'b0000;
        cpu_attack_req = 1'b0;
        cpu_block      = 1'b0;
        test_reset();
        test_p1_attack();
        test_tie();
        test_knockout();
        test_block();
        test_reset_mid_round();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
